// File: rtl/rv32i_dbus_bridge.sv
// RV32I core data port to Avalon-MM pipelined bus bridge: one outstanding
// access, held through waitrequest, read data gathered via readdatavalid, timeout abort.
module rv32i_dbus_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] c_address,
  input  logic        c_read,
  input  logic        c_write,
  input  logic [31:0] c_writedata,
  input  logic [3:0]  c_byteenable,
  output logic [31:0] c_readdata,
  output logic        c_ack,
  output logic        c_err,
  output logic        c_stall,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic        m_waitrequest
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic          TO_EN    = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] TO_SAT   = CW'(TIMEOUT_CYCLES);

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic          req_s;
  logic          load_s;
  logic          ack_err_s;
  logic          cmd_write_s;
  logic          in_bus_s;
  logic          expire_s;
  logic          is_write_r;
  logic [CW-1:0] count_r;
  logic [31:0]   m_address_r;
  logic [31:0]   m_writedata_r;
  logic [3:0]    m_byteenable_r;
  logic          m_read_r;
  logic          m_write_r;
  logic          c_ack_r;
  logic          c_err_r;
  logic [31:0]   c_readdata_r;

  assign req_s       = c_read | c_write;
  assign in_bus_s    = (state_r == ST_CMD) | (state_r == ST_RDATA);
  assign expire_s    = TO_EN & in_bus_s & (count_r == TO_LIMIT);
  assign cmd_write_s = load_s ? c_write : is_write_r;

  // Next-state selection; bus completion is checked before expiry so it wins a tie
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    ack_err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          load_s = 1'b1;
          if (c_read & c_write) begin
            next_state_s = ST_ACK;
            ack_err_s    = 1'b1;
          end else if (c_write & (c_byteenable == 4'b0000)) begin
            next_state_s = ST_ACK;
          end else begin
            next_state_s = ST_CMD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (!m_waitrequest) begin
          next_state_s = is_write_r ? ST_ACK : ST_RDATA;
        end else if (expire_s) begin
          next_state_s = ST_ACK;
          ack_err_s    = 1'b1;
        end else begin
          next_state_s = ST_CMD;
        end
      end
      ST_RDATA: begin
        if (m_readdatavalid) begin
          next_state_s = ST_ACK;
        end else if (expire_s) begin
          next_state_s = ST_ACK;
          ack_err_s    = 1'b1;
        end else begin
          next_state_s = ST_RDATA;
        end
      end
      ST_ACK:  next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, captured request fields and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      is_write_r     <= 1'b0;
      m_address_r    <= 32'h0000_0000;
      m_writedata_r  <= 32'h0000_0000;
      m_byteenable_r <= 4'b0000;
      m_read_r       <= 1'b0;
      m_write_r      <= 1'b0;
      c_ack_r        <= 1'b0;
      c_err_r        <= 1'b0;
      c_readdata_r   <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (load_s) begin
        is_write_r     <= c_write;
        m_address_r    <= c_address;
        m_writedata_r  <= c_writedata;
        m_byteenable_r <= c_byteenable;
      end
      m_read_r     <= (next_state_s == ST_CMD) & ~cmd_write_s;
      m_write_r    <= (next_state_s == ST_CMD) & cmd_write_s;
      c_ack_r      <= (next_state_s == ST_ACK);
      c_err_r      <= ack_err_s;
      // Only a genuine RDATA-state beat reaches the core; anything else reads as zero
      c_readdata_r <= ((state_r == ST_RDATA) & m_readdatavalid) ? m_readdata : 32'h0000_0000;
    end
  end

  // Timeout counter: runs while a bus phase is outstanding, saturating at the limit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (in_bus_s) begin
      count_r <= (count_r == TO_SAT) ? count_r : count_r + CW'(1'b1);
    end else begin
      count_r <= '0;
    end
  end

  assign c_stall = ~reset & (in_bus_s | ((state_r == ST_IDLE) & req_s));

  assign m_address    = m_address_r;
  assign m_writedata  = m_writedata_r;
  assign m_byteenable = m_byteenable_r;
  assign m_read       = m_read_r;
  assign m_write      = m_write_r;
  assign c_ack        = c_ack_r;
  assign c_err        = c_err_r;
  assign c_readdata   = c_readdata_r;

endmodule

// File: tb/tb_rv32i_dbus_bridge.sv
// Directed bench for rv32i_dbus_bridge with TIMEOUT_CYCLES=8; inputs change 1ns after
// each rising edge and outputs are checked inside the same cycle.
module tb_rv32i_dbus_bridge;

  logic        clk;
  logic        reset;
  logic [31:0] c_address;
  logic        c_read;
  logic        c_write;
  logic [31:0] c_writedata;
  logic [3:0]  c_byteenable;
  logic [31:0] c_readdata;
  logic        c_ack;
  logic        c_err;
  logic        c_stall;
  logic [31:0] m_address;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_waitrequest;

  int checks = 0;
  int errors = 0;

  rv32i_dbus_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .c_address(c_address), .c_read(c_read), .c_write(c_write),
    .c_writedata(c_writedata), .c_byteenable(c_byteenable),
    .c_readdata(c_readdata), .c_ack(c_ack), .c_err(c_err), .c_stall(c_stall),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; c_address = 32'h0; c_read = 1'b0; c_write = 1'b0;
    c_writedata = 32'h0; c_byteenable = 4'h0; m_readdata = 32'h0;
    m_readdatavalid = 1'b0; m_waitrequest = 1'b0;

    // Reset state, stall forced low even with a request pending
    tick(); tick();
    c_read = 1'b1;
    #1;
    chk("rst_stall", c_stall, 1'b0);
    chk("rst_mread", m_read, 1'b0);
    chk("rst_ack", c_ack, 1'b0);
    chk("rst_rdata", c_readdata, 32'h0);
    c_read = 1'b0;
    reset = 1'b0;
    tick();

    // 1: zero-wait read, data one cycle after acceptance
    c_read = 1'b1; c_address = 32'h0000_0100; m_waitrequest = 1'b0;
    #1;
    chk("t1_c0_stall", c_stall, 1'b1);
    chk("t1_c0_mread", m_read, 1'b0);
    tick();
    chk("t1_c1_mread", m_read, 1'b1);
    chk("t1_c1_maddr", m_address, 32'h0000_0100);
    chk("t1_c1_stall", c_stall, 1'b1);
    tick();
    chk("t1_c2_mread", m_read, 1'b0);
    chk("t1_c2_stall", c_stall, 1'b1);
    chk("t1_c2_ack", c_ack, 1'b0);
    m_readdatavalid = 1'b1; m_readdata = 32'hCAFE_F00D;
    tick();
    m_readdatavalid = 1'b0; m_readdata = 32'h0;
    chk("t1_c3_ack", c_ack, 1'b1);
    chk("t1_c3_err", c_err, 1'b0);
    chk("t1_c3_rdata", c_readdata, 32'hCAFE_F00D);
    chk("t1_c3_stall", c_stall, 1'b0);
    c_read = 1'b0;
    tick();
    chk("t1_c4_ack", c_ack, 1'b0);
    chk("t1_c4_rdata", c_readdata, 32'h0);

    // 2: write held through five waitrequest cycles
    c_write = 1'b1; c_address = 32'h0000_0200; c_writedata = 32'h1234_5678;
    c_byteenable = 4'b0011; m_waitrequest = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2_mwrite", m_write, 1'b1);
      chk("t2_mread", m_read, 1'b0);
      chk("t2_maddr", m_address, 32'h0000_0200);
      chk("t2_mwdata", m_writedata, 32'h1234_5678);
      chk("t2_mbe", {28'h0, m_byteenable}, 32'h3);
      chk("t2_ack_early", c_ack, 1'b0);
      if (i == 5) m_waitrequest = 1'b0;
      tick();
    end
    chk("t2_ack", c_ack, 1'b1);
    chk("t2_err", c_err, 1'b0);
    chk("t2_rdata", c_readdata, 32'h0);
    chk("t2_mwrite_off", m_write, 1'b0);
    chk("t2_mread_off", m_read, 1'b0);
    c_write = 1'b0;
    tick();

    // 3: read that never returns data times out 8 cycles after CMD entry
    c_read = 1'b1; c_address = 32'h0000_0300; m_waitrequest = 1'b0;
    tick();
    chk("t3_mread", m_read, 1'b1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("t3_ack_early", c_ack, 1'b0);
      chk("t3_stall", c_stall, 1'b1);
    end
    tick();
    chk("t3_ack", c_ack, 1'b1);
    chk("t3_err", c_err, 1'b1);
    chk("t3_rdata", c_readdata, 32'h0);
    chk("t3_mread_off", m_read, 1'b0);
    c_read = 1'b0;
    m_readdatavalid = 1'b1; m_readdata = 32'hDEAD_BEEF;
    tick();
    chk("t3_late_ack", c_ack, 1'b0);
    chk("t3_late_rdata", c_readdata, 32'h0);
    tick();
    chk("t3_idle_ack", c_ack, 1'b0);
    chk("t3_idle_rdata", c_readdata, 32'h0);
    chk("t3_idle_stall", c_stall, 1'b0);
    m_readdatavalid = 1'b0; m_readdata = 32'h0;

    // 4: illegal read+write, then byteenable-free write
    c_read = 1'b1; c_write = 1'b1; c_address = 32'h0000_0400;
    #1;
    chk("t4_ill_stall", c_stall, 1'b1);
    tick();
    chk("t4_ill_ack", c_ack, 1'b1);
    chk("t4_ill_err", c_err, 1'b1);
    chk("t4_ill_mread", m_read, 1'b0);
    chk("t4_ill_mwrite", m_write, 1'b0);
    c_read = 1'b0; c_write = 1'b0;
    tick();
    c_write = 1'b1; c_byteenable = 4'b0000;
    tick();
    chk("t4_be0_ack", c_ack, 1'b1);
    chk("t4_be0_err", c_err, 1'b0);
    chk("t4_be0_mwrite", m_write, 1'b0);
    c_write = 1'b0;
    tick();

    // 5: reset in CMD with waitrequest held, then a read with early readdatavalid
    c_write = 1'b1; c_address = 32'h0000_0500; c_byteenable = 4'hF; m_waitrequest = 1'b1;
    tick();
    chk("t5_mwrite", m_write, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_mwrite", m_write, 1'b0);
    chk("t5_rst_stall", c_stall, 1'b0);
    tick();
    chk("t5_rst_ack", c_ack, 1'b0);
    c_write = 1'b0; reset = 1'b0; m_waitrequest = 1'b0;
    tick();
    chk("t5_post_ack", c_ack, 1'b0);
    chk("t5_post_mwrite", m_write, 1'b0);
    c_read = 1'b1; c_address = 32'h0000_0504;
    tick();
    chk("t5_mread", m_read, 1'b1);
    m_readdatavalid = 1'b1; m_readdata = 32'h1111_1111;
    tick();
    m_readdatavalid = 1'b0; m_readdata = 32'h0;
    chk("t5_early_ignored", c_ack, 1'b0);
    tick();
    chk("t5_wait_ack", c_ack, 1'b0);
    m_readdatavalid = 1'b1; m_readdata = 32'h0BAD_F00D;
    tick();
    m_readdatavalid = 1'b0; m_readdata = 32'h0;
    chk("t5_ack", c_ack, 1'b1);
    chk("t5_err", c_err, 1'b0);
    chk("t5_rdata", c_readdata, 32'h0BAD_F00D);
    c_read = 1'b0;
    tick();

    // 6: back-to-back reads, request held through ACK
    c_read = 1'b1; c_address = 32'h0000_0600;
    tick();
    chk("t6_a_mread", m_read, 1'b1);
    tick();
    m_readdatavalid = 1'b1; m_readdata = 32'hAAAA_0001;
    tick();
    m_readdatavalid = 1'b0; m_readdata = 32'h0;
    c_address = 32'h0000_0604;
    #1;
    chk("t6_a_ack", c_ack, 1'b1);
    chk("t6_a_rdata", c_readdata, 32'hAAAA_0001);
    chk("t6_ack_mread", m_read, 1'b0);
    chk("t6_ack_stall", c_stall, 1'b0);
    tick();
    chk("t6_idle_mread", m_read, 1'b0);
    chk("t6_idle_ack", c_ack, 1'b0);
    chk("t6_idle_stall", c_stall, 1'b1);
    tick();
    chk("t6_b_mread", m_read, 1'b1);
    chk("t6_b_maddr", m_address, 32'h0000_0604);
    tick();
    m_readdatavalid = 1'b1; m_readdata = 32'hBBBB_0002;
    tick();
    m_readdatavalid = 1'b0; m_readdata = 32'h0;
    chk("t6_b_ack", c_ack, 1'b1);
    chk("t6_b_rdata", c_readdata, 32'hBBBB_0002);
    c_read = 1'b0;
    tick();
    chk("t6_end_ack", c_ack, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
